// File: rtl/spi_loader_pkg.sv
// Shared types and constants for the SPI-to-Wishbone loader.
package spi_loader_pkg;

    localparam int ADDR_BITS = 24;
    localparam int DATA_BITS = 16;
    localparam int CNT_BITS  = 5;

    // Counter values that mark the last bit of each serial field.
    localparam logic [CNT_BITS-1:0] ADDR_LAST = 5'd23;
    localparam logic [CNT_BITS-1:0] DATA_LAST = 5'd15;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADDR  = 3'd1,
        WE    = 3'd2,
        DATA  = 3'd3,
        BUS   = 3'd4,
        DONE  = 3'd5,
        RDOUT = 3'd6
    } state_e;

endpackage

// File: rtl/spi_loader_if.sv
// Wishbone master bus bundle driven by the SPI loader.
interface spi_loader_if;
    import spi_loader_pkg::*;

    logic                 o_wb_cyc;
    logic                 o_wb_stb;
    logic                 o_wb_we;
    logic [ADDR_BITS-1:0] o_wb_adr;
    logic [DATA_BITS-1:0] o_wb_dat;
    logic [DATA_BITS-1:0] i_wb_dat;
    logic                 i_wb_ack;
    logic                 i_wb_err;

    modport master (
        output o_wb_cyc, o_wb_stb, o_wb_we, o_wb_adr, o_wb_dat,
        input  i_wb_dat, i_wb_ack, i_wb_err
    );

    modport slave (
        input  o_wb_cyc, o_wb_stb, o_wb_we, o_wb_adr, o_wb_dat,
        output i_wb_dat, i_wb_ack, i_wb_err
    );

endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser with a registered falling-edge pulse.
// STAGES must be at least 2. All flops reset high so that releasing
// reset while the line idles high never produces a false edge.
module spi_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic fall
);

    logic [STAGES-1:0] sync_r;
    logic              prev_r;
    logic              fall_r;

    // Synchronise the input and flag a high-to-low transition of the settled level.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_r <= {STAGES{1'b1}};
            prev_r <= 1'b1;
            fall_r <= 1'b0;
        end else begin
            sync_r <= {sync_r[STAGES-2:0], din};
            prev_r <= sync_r[STAGES-1];
            fall_r <= prev_r & ~sync_r[STAGES-1];
        end
    end

    assign fall = fall_r;

endmodule

// File: rtl/spi_loader.sv
// SPI-style serial loader that issues one Wishbone access per frame.
// Frame (LSB first): start 0, 24 address bits, WE bit, 16 data bits if WE=1.
// miso reads 1 while busy, 0 when the access has finished, then carries
// read data for reads.
module spi_loader
    import spi_loader_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_spi_clk,
    input  logic           i_spi_mosi,
    output logic           o_spi_miso,
    output logic           o_err,
    spi_loader_if.master   wb
);

    logic                   spi_fall_s;
    logic                   mosi_s;
    logic [SYNC_STAGES-1:0] mosi_sync_r;

    state_e                 state_r;
    logic [CNT_BITS-1:0]    cnt_r;
    logic [ADDR_BITS-1:0]   adr_r;
    logic [DATA_BITS-1:0]   dat_r;
    logic [DATA_BITS-1:0]   rd_r;
    logic                   we_r;
    logic                   cyc_r;
    logic                   stb_r;
    logic                   miso_r;
    logic                   err_r;

    spi_sync_edge #(
        .STAGES (SYNC_STAGES)
    ) u_spi_clk_edge (
        .clk  (i_clk),
        .rst  (i_rst),
        .din  (i_spi_clk),
        .fall (spi_fall_s)
    );

    // Plain synchroniser for serial data; reset high to match the idle line.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            mosi_sync_r <= {SYNC_STAGES{1'b1}};
        end else begin
            mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], i_spi_mosi};
        end
    end

    assign mosi_s = mosi_sync_r[SYNC_STAGES-1];

    // Frame decoder, Wishbone master and read-back shifter in one state machine.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r <= IDLE;
            cnt_r   <= 5'd0;
            adr_r   <= 24'd0;
            dat_r   <= 16'd0;
            rd_r    <= 16'd0;
            we_r    <= 1'b0;
            cyc_r   <= 1'b0;
            stb_r   <= 1'b0;
            miso_r  <= 1'b1;
            err_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    // Only a sampled 0 is a start bit; idle-high bits are ignored.
                    if (spi_fall_s && !mosi_s) begin
                        state_r <= ADDR;
                        cnt_r   <= 5'd0;
                    end
                end
                ADDR: begin
                    if (spi_fall_s) begin
                        adr_r <= {mosi_s, adr_r[ADDR_BITS-1:1]};
                        if (cnt_r == ADDR_LAST) begin
                            state_r <= WE;
                            cnt_r   <= 5'd0;
                        end else begin
                            cnt_r <= cnt_r + 5'd1;
                        end
                    end
                end
                WE: begin
                    if (spi_fall_s) begin
                        we_r    <= mosi_s;
                        cnt_r   <= 5'd0;
                        state_r <= mosi_s ? DATA : BUS;
                    end
                end
                DATA: begin
                    if (spi_fall_s) begin
                        dat_r <= {mosi_s, dat_r[DATA_BITS-1:1]};
                        if (cnt_r == DATA_LAST) begin
                            state_r <= BUS;
                            cnt_r   <= 5'd0;
                        end else begin
                            cnt_r <= cnt_r + 5'd1;
                        end
                    end
                end
                BUS: begin
                    // Serial edges are ignored here; the bus handshake is purely registered.
                    if (!cyc_r) begin
                        cyc_r <= 1'b1;
                        stb_r <= 1'b1;
                    end else if (wb.i_wb_ack || wb.i_wb_err) begin
                        cyc_r   <= 1'b0;
                        stb_r   <= 1'b0;
                        miso_r  <= 1'b0;
                        state_r <= DONE;
                        cnt_r   <= 5'd0;
                        if (!we_r) begin
                            rd_r <= wb.i_wb_dat;
                        end
                        if (wb.i_wb_err) begin
                            err_r <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (spi_fall_s) begin
                        cnt_r <= 5'd0;
                        if (we_r) begin
                            state_r <= IDLE;
                            miso_r  <= 1'b1;
                        end else begin
                            state_r <= RDOUT;
                            miso_r  <= rd_r[0];
                            rd_r    <= {1'b0, rd_r[DATA_BITS-1:1]};
                        end
                    end
                end
                RDOUT: begin
                    if (spi_fall_s) begin
                        if (cnt_r == DATA_LAST) begin
                            state_r <= IDLE;
                            miso_r  <= 1'b1;
                            cnt_r   <= 5'd0;
                        end else begin
                            miso_r <= rd_r[0];
                            rd_r   <= {1'b0, rd_r[DATA_BITS-1:1]};
                            cnt_r  <= cnt_r + 5'd1;
                        end
                    end
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= 5'd0;
                    cyc_r   <= 1'b0;
                    stb_r   <= 1'b0;
                    miso_r  <= 1'b1;
                end
            endcase
        end
    end

    assign wb.o_wb_cyc = cyc_r;
    assign wb.o_wb_stb = stb_r;
    assign wb.o_wb_we  = we_r;
    assign wb.o_wb_adr = adr_r;
    assign wb.o_wb_dat = dat_r;
    assign o_spi_miso  = miso_r;
    assign o_err       = err_r;

endmodule

// File: tb/tb_spi_loader.sv
// Directed bench: serial host tasks, a Wishbone slave model and a
// transaction scoreboard of expected bus accesses.
module tb_spi_loader;
    import spi_loader_pkg::*;

    localparam int HALF = 8;

    typedef struct packed {
        logic        we;
        logic [23:0] adr;
        logic [15:0] dat;
    } txn_t;

    logic clk;
    logic rst;
    logic spi_clk;
    logic spi_mosi;
    logic spi_miso;
    logic err;
    logic m;

    int n_tests = 0;
    int n_fail  = 0;

    int          ack_delay = 3;
    logic        use_err   = 1'b0;
    logic [15:0] rdata     = 16'h0000;

    txn_t exp_q[$];
    txn_t obs_q[$];

    // Expected read-back bit order for slave data 0xA5C3.
    logic rd_seq [16] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1,
                          1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    spi_loader_if wb_if ();

    spi_loader #(
        .SYNC_STAGES (2)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_spi_clk  (spi_clk),
        .i_spi_mosi (spi_mosi),
        .o_spi_miso (spi_miso),
        .o_err      (err),
        .wb         (wb_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // One serial period: data set while high, miso sampled at end of high, then falling edge.
    task automatic spi_period(input logic b, output logic mo);
        spi_mosi = b;
        spi_clk  = 1'b1;
        repeat (HALF) @(negedge clk);
        mo = spi_miso;
        spi_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        spi_clk = 1'b1;
    endtask

    task automatic send_frame(input logic we, input logic [23:0] a, input logic [15:0] d);
        txn_t t;
        logic mo;
        spi_period(1'b0, mo);
        for (int i = 0; i < 24; i++) spi_period(a[i], mo);
        spi_period(we, mo);
        if (we) begin
            for (int i = 0; i < 16; i++) spi_period(d[i], mo);
        end
        spi_mosi = 1'b1;
        t.we  = we;
        t.adr = a;
        t.dat = d;
        exp_q.push_back(t);
    endtask

    task automatic wait_done();
        int n = 0;
        while (spi_miso !== 1'b0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("miso_done", spi_miso, 1'b0);
    endtask

    task automatic check_txn();
        txn_t o;
        txn_t e;
        check("wb_cycle_count", obs_q.size(), 1);
        if (obs_q.size() != 0 && exp_q.size() != 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            check("txn_we", o.we, e.we);
            check("txn_adr", o.adr, e.adr);
            if (e.we) check("txn_dat", o.dat, e.dat);
        end
        while (obs_q.size() != 0) void'(obs_q.pop_front());
        while (exp_q.size() != 0) void'(exp_q.pop_front());
    endtask

    task automatic finish_write();
        logic mo;
        spi_period(1'b1, mo);
        check("miso_done_hold", mo, 1'b0);
        check("miso_idle", spi_miso, 1'b1);
    endtask

    // Wishbone slave: acks (or errs) after ack_delay cycles and checks bus stability while stalled.
    initial begin
        txn_t held;
        int   wait_cnt = 0;
        wb_if.i_wb_ack = 1'b0;
        wb_if.i_wb_err = 1'b0;
        wb_if.i_wb_dat = 16'h0000;
        forever begin
            @(negedge clk);
            if (wb_if.i_wb_ack || wb_if.i_wb_err) begin
                wb_if.i_wb_ack = 1'b0;
                wb_if.i_wb_err = 1'b0;
                wait_cnt = 0;
                check("cyc_drop", {wb_if.o_wb_cyc, wb_if.o_wb_stb}, 2'b00);
            end else if (wb_if.o_wb_cyc && wb_if.o_wb_stb) begin
                if (wait_cnt == 0) begin
                    held.we  = wb_if.o_wb_we;
                    held.adr = wb_if.o_wb_adr;
                    held.dat = wb_if.o_wb_dat;
                end else begin
                    check("bus_stable", {wb_if.o_wb_we, wb_if.o_wb_adr, wb_if.o_wb_dat}, held);
                    check("miso_busy", spi_miso, 1'b1);
                end
                wait_cnt++;
                if (wait_cnt >= ack_delay) begin
                    wb_if.i_wb_dat = rdata;
                    if (use_err) wb_if.i_wb_err = 1'b1;
                    else         wb_if.i_wb_ack = 1'b1;
                    obs_q.push_back(held);
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // Directed sequence.
    initial begin
        rst      = 1'b1;
        spi_clk  = 1'b1;
        spi_mosi = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_miso", spi_miso, 1'b1);
        check("rst_cyc_stb_we", {wb_if.o_wb_cyc, wb_if.o_wb_stb, wb_if.o_wb_we}, 3'b000);
        check("rst_adr", wb_if.o_wb_adr, 24'h000000);
        check("rst_dat", wb_if.o_wb_dat, 16'h0000);
        check("rst_err", err, 1'b0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Idle ones are ignored, then a single write.
        spi_period(1'b1, m);
        spi_period(1'b1, m);
        check("idle_no_cycle", obs_q.size(), 0);
        ack_delay = 3;
        send_frame(1'b1, 24'h800000, 16'h000E);
        wait_done();
        check_txn();
        finish_write();

        // Back-to-back writes.
        send_frame(1'b1, 24'h800021, 16'h3888);
        wait_done();
        check_txn();
        finish_write();
        send_frame(1'b1, 24'h800022, 16'h0005);
        wait_done();
        check_txn();
        finish_write();

        // Read with serial read-back.
        rdata = 16'hA5C3;
        send_frame(1'b0, 24'h000010, 16'h0000);
        wait_done();
        check_txn();
        spi_period(1'b1, m);
        check("rd_done_miso", m, 1'b0);
        for (int i = 0; i < 16; i++) begin
            spi_period(1'b1, m);
            check("rd_bit", m, rd_seq[i]);
        end
        repeat (4) @(negedge clk);
        check("rd_idle_miso", spi_miso, 1'b1);

        // Error termination sets the sticky flag.
        check("err_before", err, 1'b0);
        use_err = 1'b1;
        send_frame(1'b1, 24'h0000AA, 16'h1111);
        wait_done();
        check_txn();
        finish_write();
        check("err_set", err, 1'b1);
        use_err = 1'b0;
        send_frame(1'b1, 24'h0000AB, 16'h2222);
        wait_done();
        check_txn();
        finish_write();
        check("err_sticky", err, 1'b1);

        // Reset mid-frame discards the partial frame.
        spi_period(1'b0, m);
        for (int i = 0; i < 10; i++) spi_period(1'b1, m);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("midrst_err", err, 1'b0);
        check("midrst_adr", wb_if.o_wb_adr, 24'h000000);
        check("midrst_miso", spi_miso, 1'b1);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        send_frame(1'b1, 24'h000123, 16'hBEEF);
        wait_done();
        check_txn();
        finish_write();

        // Slave stall while the serial clock keeps toggling.
        ack_delay = 50;
        send_frame(1'b1, 24'h5A5A5A, 16'h1234);
        spi_period(1'b1, m);
        spi_period(1'b1, m);
        check("stall_cyc", wb_if.o_wb_cyc, 1'b1);
        check("stall_miso", spi_miso, 1'b1);
        wait_done();
        check_txn();
        finish_write();

        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_loader.md
SPI_LOADER -- requirements
Module: spi_loader

Interface
REQ-001 Parameter SYNC_STAGES, default 2: number of flops synchronising i_spi_clk and i_spi_mosi into i_clk.
REQ-002 i_clk  in  1  system clock; single clock domain, all state updates on its rising edge.
REQ-003 i_rst  in  1  reset, synchronous, active-high.
REQ-004 i_spi_clk  in  1  external SPI clock, asynchronous; idles high.
REQ-005 i_spi_mosi  in  1  external serial data, asynchronous; idles high.
REQ-006 o_spi_miso  out  1  busy/ready and read-data line to the external host.
REQ-007 o_wb_cyc, o_wb_stb  out  1 each  Wishbone master cycle and strobe.
REQ-008 o_wb_we  out  1  Wishbone write enable.
REQ-009 o_wb_adr  out  24  Wishbone word address, taken from the frame address field.
REQ-010 o_wb_dat  out  16  Wishbone write data.
REQ-011 i_wb_dat  in  16  Wishbone read data.
REQ-012 i_wb_ack, i_wb_err  in  1 each  Wishbone termination; err terminates the cycle exactly as ack does.
REQ-013 o_err  out  1  sticky flag, set by any i_wb_err termination.

Function
REQ-014 The block SHALL sample mosi only on a synchronised falling edge of spi_clk (high-to-low of the last two synchronised samples).
REQ-015 The block SHALL use this frame format, all fields LSB first: start bit 0, 24 address bits, 1 WE bit, then 16 data bits when WE=1.
REQ-016 In state IDLE, a sampled 1 SHALL be ignored and a sampled 0 SHALL go to ADDR with the bit counter cleared.
REQ-017 ADDR SHALL shift 24 bits into the address register and then go to WE.
REQ-018 WE SHALL latch the WE bit. WE=1 goes to DATA; WE=0 goes to BUS.
REQ-019 DATA SHALL shift 16 bits into the data register and then go to BUS.
REQ-020 BUS SHALL assert cyc and stb with the latched adr, we and dat, starting on the cycle after entry.
REQ-021 BUS SHALL hold cyc, stb, adr, we and dat stable until ack or err. It SHALL then deassert cyc and stb on the next cycle, capture i_wb_dat on a read, and go to DONE.
REQ-022 o_spi_miso SHALL be 1 in IDLE, ADDR, WE, DATA and BUS, and 0 in DONE.
REQ-023 From DONE, the next spi_clk falling edge SHALL return a write to IDLE and move a read to RDOUT.
REQ-024 RDOUT SHALL drive captured read data bit i on miso during the i-th spi_clk period, LSB first, updating after each falling edge. After the 16th falling edge it SHALL go to IDLE with miso=1.
REQ-025 spi_clk edges arriving while in BUS SHALL be ignored; mosi is not sampled during BUS.
REQ-026 The bit counter SHALL be 5 bits wide and SHALL clear on every state change.
REQ-027 Minimum supported spi_clk half-period SHALL be SYNC_STAGES+1 i_clk cycles.
REQ-028 A frame SHALL issue exactly one Wishbone cycle; back-to-back frames SHALL need no gap beyond the DONE edge.

Reset
REQ-029 While i_rst=1, the state SHALL be IDLE and o_spi_miso SHALL be 1.
REQ-030 While i_rst=1, cyc, stb, we and o_err SHALL be 0, and adr, dat, the shift registers and the counter SHALL be 0.
REQ-031 i_rst asserted mid-frame or mid-bus-cycle SHALL abort at once, drop cyc/stb on that edge, and discard the partial frame.
REQ-032 The synchroniser flops SHALL reset to 1, so that no spurious falling edge is seen on release.

Structure
REQ-033 A shared package SHALL hold the state enum (IDLE, ADDR, WE, DATA, BUS, DONE, RDOUT) and the constants ADDR_BITS=24 and DATA_BITS=16.
REQ-034 There SHALL be one sub-module, spi_sync_edge: a parameterised synchroniser plus falling-edge detector, instantiated once for spi_clk (mosi uses a plain synchroniser).
REQ-035 The Wishbone side SHALL have no combinational path from i_wb_ack to o_wb_stb.

Verification
REQ-036 Two idle clocks with mosi=1, then frame addr=0x800000, we=1, dat=0x000E, ack after 3 cycles -> exactly one write cycle with adr=0x800000 and dat=0x000E; miso goes 0, then 1 after the next spi_clk edge.
REQ-037 Write frames addr=0x800021/dat=0x3888 then addr=0x800022/dat=0x0005 back-to-back -> two write cycles in order with matching adr/dat; no extra cycles.
REQ-038 Read frame addr=0x000010 with slave returning 0xA5C3 -> one cycle with we=0; miso goes 0, then shifts 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1 over 16 periods, then idles at 1.
REQ-039 Write frame with slave answering err instead of ack -> cycle terminates, o_err=1 and stays 1 through further frames until i_rst.
REQ-040 i_rst pulsed after 10 address bits, then a full frame addr=0x000123/dat=0xBEEF -> only the 0x000123/0xBEEF write occurs.
REQ-041 Slave stalls ack for 50 cycles while spi_clk keeps toggling -> cyc/stb/adr/dat stable throughout, miso stays 1 until ack.
